// File: rtl/riscv_lsu_ctrl_if.sv
// Core-side request/response and data-memory port bundle for riscv_lsu_ctrl.
// master: core + memory environment side, slave: the load/store controller.
interface riscv_lsu_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  is_store;
  logic [2:0]            funct3;
  logic [4:0]            rd;
  logic [31:0]           rs1_data;
  logic [31:0]           rs2_data;
  logic [31:0]           imm_i_sext;
  logic [31:0]           imm_s_sext;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic                  mem_rsp_valid;
  logic [31:0]           mem_rdata;
  logic                  resp_valid;
  logic                  resp_wb;
  logic [4:0]            resp_rd;
  logic [31:0]           resp_data;
  logic                  resp_err;
  logic                  resp_misalign;

  modport master (
    output req_valid, is_store, funct3, rd, rs1_data, rs2_data, imm_i_sext, imm_s_sext,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
    input  resp_valid, resp_wb, resp_rd, resp_data, resp_err, resp_misalign
  );

  modport slave (
    input  req_valid, is_store, funct3, rd, rs1_data, rs2_data, imm_i_sext, imm_s_sext,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, mem_req_valid, mem_addr, mem_we, mem_be, mem_wdata,
    output resp_valid, resp_wb, resp_rd, resp_data, resp_err, resp_misalign
  );
endinterface

// File: rtl/riscv_lsu_ctrl.sv
// Load/store sequencer: one access outstanding, valid/ready data-memory port,
// load data extraction/extension and completion pulse to writeback.
// Optional macro RISCV_LSU_MISALIGN_TRAP_EN: trap misaligned H/W accesses
// instead of issuing them to the containing word.
module riscv_lsu_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  riscv_lsu_ctrl_if.slave  bus
);
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [1:0]            ea_lo_q, ea_lo_d;
  logic [2:0]            f3_q, f3_d;
  logic                  store_q, store_d;
  logic [4:0]            rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_wb_q, resp_wb_d;
  logic [4:0]            resp_rd_q, resp_rd_d;
  logic [31:0]           resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;
  logic                  resp_mis_q, resp_mis_d;

  logic [31:0] ea_c;
  logic        illegal_c;
  logic        misalign_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_data_c;

  // Effective address, legality, misalignment and store lane formation.
  always_comb begin
    ea_c = bus.rs1_data + (bus.is_store ? bus.imm_s_sext : bus.imm_i_sext);
    if (bus.is_store) illegal_c = bus.funct3[2] | (bus.funct3[1:0] == 2'b11);
    else              illegal_c = (bus.funct3 == 3'b011) | (bus.funct3[2:1] == 2'b11);
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    misalign_c = ~illegal_c & (((bus.funct3[1:0] == 2'b01) & ea_c[0]) |
                               ((bus.funct3[1:0] == 2'b10) & (ea_c[1:0] != 2'b00)));
`else
    misalign_c = 1'b0;
`endif
    case (bus.funct3[1:0])
      2'b00:   begin be_c = 4'b0001 << ea_c[1:0];             wdata_c = {4{bus.rs2_data[7:0]}};  end
      2'b01:   begin be_c = ea_c[1] ? 4'b1100 : 4'b0011;      wdata_c = {2{bus.rs2_data[15:0]}}; end
      default: begin be_c = 4'b1111;                          wdata_c = bus.rs2_data;            end
    endcase
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    case (ea_lo_q)
      2'd0:    byte_c = bus.mem_rdata[7:0];
      2'd1:    byte_c = bus.mem_rdata[15:8];
      2'd2:    byte_c = bus.mem_rdata[23:16];
      default: byte_c = bus.mem_rdata[31:24];
    endcase
    half_c = ea_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_data_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  load_data_c = {24'd0, byte_c};
      3'b001:  load_data_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_data_c = {16'd0, half_c};
      default: load_data_c = bus.mem_rdata;
    endcase
  end

  // Next-state and next-output logic; completion fields default to zero.
  always_comb begin
    state_d         = state_q;
    ea_lo_d         = ea_lo_q;
    f3_d            = f3_q;
    store_d         = store_q;
    rd_d            = rd_q;
    cnt_d           = cnt_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    mem_we_d        = mem_we_q;
    mem_be_d        = mem_be_q;
    mem_wdata_d     = mem_wdata_q;
    resp_valid_d    = 1'b0;
    resp_wb_d       = 1'b0;
    resp_rd_d       = 5'd0;
    resp_data_d     = 32'd0;
    resp_err_d      = 1'b0;
    resp_mis_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.req_valid) begin
          ea_lo_d = ea_c[1:0];
          f3_d    = bus.funct3;
          store_d = bus.is_store;
          rd_d    = bus.rd;
          if (illegal_c | misalign_c) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rd_d    = bus.rd;
            resp_err_d   = 1'b1;
            resp_mis_d   = misalign_c;
          end else begin
            state_d         = S_REQ;
            mem_req_valid_d = 1'b1;
            mem_addr_d      = ADDR_WIDTH'(ea_c) & ~ADDR_WIDTH'(3);
            mem_we_d        = bus.is_store;
            mem_be_d        = be_c;
            mem_wdata_d     = wdata_c;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          if (store_q) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rd_d    = rd_q;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.mem_rsp_valid) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_wb_d    = 1'b1;
          resp_rd_d    = rd_q;
          resp_data_d  = load_data_c;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rd_d    = rd_q;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Captured request context and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_lo_q         <= 2'd0;
      f3_q            <= 3'd0;
      store_q         <= 1'b0;
      rd_q            <= 5'd0;
      cnt_q           <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_we_q        <= 1'b0;
      mem_be_q        <= 4'd0;
      mem_wdata_q     <= 32'd0;
      resp_valid_q    <= 1'b0;
      resp_wb_q       <= 1'b0;
      resp_rd_q       <= 5'd0;
      resp_data_q     <= 32'd0;
      resp_err_q      <= 1'b0;
      resp_mis_q      <= 1'b0;
    end else begin
      ea_lo_q         <= ea_lo_d;
      f3_q            <= f3_d;
      store_q         <= store_d;
      rd_q            <= rd_d;
      cnt_q           <= cnt_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_we_q        <= mem_we_d;
      mem_be_q        <= mem_be_d;
      mem_wdata_q     <= mem_wdata_d;
      resp_valid_q    <= resp_valid_d;
      resp_wb_q       <= resp_wb_d;
      resp_rd_q       <= resp_rd_d;
      resp_data_q     <= resp_data_d;
      resp_err_q      <= resp_err_d;
      resp_mis_q      <= resp_mis_d;
    end
  end

  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_be        = mem_be_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_wb       = resp_wb_q;
  assign bus.resp_rd       = resp_rd_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.resp_misalign = resp_mis_q;
endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// Directed bench for riscv_lsu_ctrl with a response scoreboard.
// Honours RISCV_LSU_MISALIGN_TRAP_EN for the misaligned-word case.
module tb_riscv_lsu_ctrl;
  logic clk = 1'b0;
  logic rst_n;

  riscv_lsu_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  riscv_lsu_ctrl #(.ADDR_WIDTH(32), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t mk(input logic wb, input logic [4:0] rd, input logic [31:0] data,
                              input logic err, input logic mis);
    exp_t e;
    e.wb = wb; e.rd = rd; e.data = data; e.err = err; e.mis = mis;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expired(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s observed=no event expected=event within bound", tag);
  endtask

  // Present one request, hold until accepted, then scramble the request inputs.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input bit push, input exp_t e);
    int k = 0;
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    if (!bus.req_ready) expired("req_ready_wait");
    bus.req_valid  = 1'b1;
    bus.is_store   = st;
    bus.funct3     = f3;
    bus.rd         = rd;
    bus.rs1_data   = rs1;
    bus.rs2_data   = rs2;
    bus.imm_i_sext = st ? 32'h0BAD_0BAD : imm;
    bus.imm_s_sext = st ? imm : 32'h0BAD_0BAD;
    if (push) sb.push_back(e);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.rs1_data   = $urandom;
    bus.rs2_data   = $urandom;
    bus.imm_i_sext = $urandom;
    bus.imm_s_sext = $urandom;
    bus.rd         = 5'($urandom);
    chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
  endtask

  // Wait for the memory request, stall it, check stability, then complete the handshake.
  task automatic expect_mem(input string tag, input logic [31:0] addr, input logic [3:0] be,
                            input logic we, input logic [31:0] wdata, input int stall);
    int k = 0;
    while (!bus.mem_req_valid && k < 20) begin @(negedge clk); k++; end
    if (!bus.mem_req_valid) expired({tag, "_mem_req"});
    for (int i = 0; i <= stall; i++) begin
      chk({tag, "_addr"}, bus.mem_addr, addr);
      chk({tag, "_be"}, 32'(bus.mem_be), 32'(be));
      chk({tag, "_we"}, 32'(bus.mem_we), 32'(we));
      if (we) chk({tag, "_wdata"}, bus.mem_wdata, wdata);
      if (i < stall) begin
        chk({tag, "_req_ready_stall"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_mem_req_held"}, 32'(bus.mem_req_valid), 32'd1);
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
      end
    end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk({tag, "_mem_req_drop"}, 32'(bus.mem_req_valid), 32'd0);
  endtask

  task automatic mem_respond(input int delay, input logic [31:0] d);
    repeat (delay) @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = d;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = $urandom;
  endtask

  // Wait for the completion pulse and compare against the scoreboard head.
  task automatic wait_resp(input string tag);
    exp_t e;
    int   k = 0;
    while (!bus.resp_valid && k < 40) begin @(negedge clk); k++; end
    if (!bus.resp_valid) expired({tag, "_resp"});
    else if (sb.size() == 0) expired({tag, "_sb_empty"});
    else begin
      e = sb.pop_front();
      chk({tag, "_wb"}, 32'(bus.resp_wb), 32'(e.wb));
      chk({tag, "_rd"}, 32'(bus.resp_rd), 32'(e.rd));
      chk({tag, "_data"}, bus.resp_data, e.data);
      chk({tag, "_err"}, 32'(bus.resp_err), 32'(e.err));
      chk({tag, "_mis"}, 32'(bus.resp_misalign), 32'(e.mis));
      @(negedge clk);
      chk({tag, "_pulse_end"}, 32'(bus.resp_valid), 32'd0);
      chk({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=time limit expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n             = 1'b0;
    bus.req_valid     = 1'b0;
    bus.is_store      = 1'b0;
    bus.funct3        = 3'd0;
    bus.rd            = 5'd0;
    bus.rs1_data      = 32'd0;
    bus.rs2_data      = 32'd0;
    bus.imm_i_sext    = 32'd0;
    bus.imm_s_sext    = 32'd0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'd0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // LW, response two cycles after accept
    issue(1'b0, 3'b010, 5'd5, 32'h0000_1000, 32'h0, 32'h10, 1'b1, mk(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0));
    expect_mem("lw", 32'h0000_1010, 4'b1111, 1'b0, 32'h0, 0);
    mem_respond(0, 32'hDEAD_BEEF);
    wait_resp("lw");

    // LB / LBU at ea 0x1003
    issue(1'b0, 3'b000, 5'd7, 32'h0000_1000, 32'h0, 32'h3, 1'b1, mk(1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 1'b0));
    expect_mem("lb", 32'h0000_1000, 4'b1000, 1'b0, 32'h0, 0);
    mem_respond(0, 32'h8012_3456);
    wait_resp("lb");
    issue(1'b0, 3'b100, 5'd7, 32'h0000_1000, 32'h0, 32'h3, 1'b1, mk(1'b1, 5'd7, 32'h0000_0080, 1'b0, 1'b0));
    expect_mem("lbu", 32'h0000_1000, 4'b1000, 1'b0, 32'h0, 0);
    mem_respond(5, 32'h8012_3456);
    wait_resp("lbu");

    // LH upper half / LHU lower half
    issue(1'b0, 3'b001, 5'd8, 32'h0000_1000, 32'h0, 32'h2, 1'b1, mk(1'b1, 5'd8, 32'hFFFF_8001, 1'b0, 1'b0));
    expect_mem("lh", 32'h0000_1000, 4'b1100, 1'b0, 32'h0, 0);
    mem_respond(1, 32'h8001_7FFF);
    wait_resp("lh");
    issue(1'b0, 3'b101, 5'd9, 32'h0000_1000, 32'h0, 32'h0, 1'b1, mk(1'b1, 5'd9, 32'h0000_7FFF, 1'b0, 1'b0));
    expect_mem("lhu", 32'h0000_1000, 4'b0011, 1'b0, 32'h0, 0);
    mem_respond(0, 32'h8001_7FFF);
    wait_resp("lhu");

    // SH: completion exactly one cycle after the memory handshake
    issue(1'b1, 3'b001, 5'd3, 32'h0000_2000, 32'h1234_ABCD, 32'h2, 1'b1, mk(1'b0, 5'd3, 32'h0, 1'b0, 1'b0));
    expect_mem("sh", 32'h0000_2000, 4'b1100, 1'b1, 32'hABCD_ABCD, 0);
    chk("sh_resp_now", 32'(bus.resp_valid), 32'd1);
    wait_resp("sh");

    // SB lane replication
    issue(1'b1, 3'b000, 5'd4, 32'h0000_2000, 32'hFFFF_FFA5, 32'h1, 1'b1, mk(1'b0, 5'd4, 32'h0, 1'b0, 1'b0));
    expect_mem("sb", 32'h0000_2000, 4'b0010, 1'b1, 32'hA5A5_A5A5, 0);
    wait_resp("sb");

    // SW with negative offset and five stall cycles
    issue(1'b1, 3'b010, 5'd2, 32'h0000_3000, 32'hCAFE_F00D, 32'hFFFF_FFFC, 1'b1, mk(1'b0, 5'd2, 32'h0, 1'b0, 1'b0));
    expect_mem("sw_stall", 32'h0000_2FFC, 4'b1111, 1'b1, 32'hCAFE_F00D, 5);
    wait_resp("sw_stall");

    // Illegal funct3: load 011, store 100 -> no memory access
    issue(1'b0, 3'b011, 5'd11, 32'h0000_1000, 32'h0, 32'h0, 1'b1, mk(1'b0, 5'd11, 32'h0, 1'b1, 1'b0));
    chk("ill_ld_no_mem", 32'(bus.mem_req_valid), 32'd0);
    wait_resp("ill_ld");
    issue(1'b1, 3'b100, 5'd12, 32'h0000_1000, 32'h5555_5555, 32'h0, 1'b1, mk(1'b0, 5'd12, 32'h0, 1'b1, 1'b0));
    chk("ill_st_no_mem", 32'(bus.mem_req_valid), 32'd0);
    wait_resp("ill_st");

    // Misaligned LW at ea 0x1002
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    issue(1'b0, 3'b010, 5'd13, 32'h0000_1000, 32'h0, 32'h2, 1'b1, mk(1'b0, 5'd13, 32'h0, 1'b1, 1'b1));
    chk("mis_no_mem", 32'(bus.mem_req_valid), 32'd0);
    wait_resp("mis_lw");
`else
    issue(1'b0, 3'b010, 5'd13, 32'h0000_1000, 32'h0, 32'h2, 1'b1, mk(1'b1, 5'd13, 32'h1122_3344, 1'b0, 1'b0));
    expect_mem("mis_lw", 32'h0000_1000, 4'b1111, 1'b0, 32'h0, 0);
    mem_respond(0, 32'h1122_3344);
    wait_resp("mis_lw");
`endif

    // Timeout (TIMEOUT=8), then a late response must be dropped
    issue(1'b0, 3'b010, 5'd14, 32'h0000_4000, 32'h0, 32'h8, 1'b1, mk(1'b0, 5'd14, 32'h0, 1'b1, 1'b0));
    expect_mem("tmo", 32'h0000_4008, 4'b1111, 1'b0, 32'h0, 0);
    wait_resp("tmo");
    mem_respond(0, 32'h7777_7777);
    chk("late_rsp_ignored", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    chk("late_rsp_ignored2", 32'(bus.resp_valid), 32'd0);

    // Reset asserted while waiting for load data aborts the access
    issue(1'b0, 3'b010, 5'd15, 32'h0000_5000, 32'h0, 32'h0, 1'b0, mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
    expect_mem("rst_wait", 32'h0000_5000, 4'b1111, 1'b0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_wait_mem_req", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_wait_resp", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_respond(0, 32'h9999_9999);
    for (int i = 0; i < 3; i++) begin
      chk("rst_wait_no_resp", 32'(bus.resp_valid), 32'd0);
      @(negedge clk);
    end

    // Recovery: LW with base+offset wrapping mod 2^32
    issue(1'b0, 3'b010, 5'd31, 32'hFFFF_FFF0, 32'h0, 32'h20, 1'b1, mk(1'b1, 5'd31, 32'h0BAD_F00D, 1'b0, 1'b0));
    expect_mem("wrap_lw", 32'h0000_0010, 4'b1111, 1'b0, 32'h0, 0);
    mem_respond(2, 32'h0BAD_F00D);
    wait_resp("wrap_lw");

    if (sb.size() != 0) expired("sb_leftover");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
